// File: rtl/andrewm_uart_tx_scheduler.sv
// andrewm_uart_tx_scheduler: four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Optional feature macro UART_TX_PARITY_EN adds an even-parity bit after the data bits (8E1 framing).
module andrewm_uart_tx_scheduler #(
    parameter int unsigned BAUD_DIV = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        uart_tx,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 32'd1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic        tx_q, tx_d;
    logic [1:0]  win_s;
    logic        win_vld_s;
    logic [1:0]  cand_s;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        win_s     = 2'd0;
        win_vld_s = 1'b0;
        cand_s    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last_q + k[1:0];
            if (!win_vld_s && req_valid[cand_s]) begin
                win_s     = cand_s;
                win_vld_s = 1'b1;
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: every line state lasts BAUD_DIV cycles via the down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        grant_d = grant_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d = ST_START;
                    cnt_d   = RELOAD;
                    bit_d   = 3'd0;
                    shift_d = req_data[{win_s, 3'b000} +: 8];
                    last_d  = win_s;
                    grant_d = win_s;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^req_data[{win_s, 3'b000} +: 8];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_DATA;
                    cnt_d   = RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_STOP;
                    cnt_d   = RELOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs; the line level is computed from the next state so uart_tx stays a flop.
    always_comb begin
        req_ready  = 4'b0000;
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_STOP) && (cnt_q == 16'd0);
        if ((state_q == ST_IDLE) && win_vld_s && !reset) begin
            req_ready = 4'b0001 << win_s;
        end else begin
            req_ready = 4'b0000;
        end
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign uart_tx  = tx_q;
    assign grant_id = grant_q;

endmodule
